imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader: header word count, LE data words to IMEM, XOR checksum
module imem_loader #(
  parameter int IMEM_SIZE = 256,
  parameter int IMEM_BITS = 22
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [IMEM_BITS-1:0] wr_addr,
  output logic [31:0]          wr_data,
  output logic                 cpu_hold,
  output logic                 done,
  output logic [1:0]           err
);

  // Wide enough to hold IMEM_SIZE itself, so a full-size image is legal.
  localparam int CW = $clog2(IMEM_SIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] n_words;
  logic [7:0]    csum;
  logic [31:0]   shreg;
  logic [31:0]   next_word;
  logic          accept;

  assign in_ready  = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
  assign cpu_hold  = in_ready || wr_en;
  assign accept    = in_valid && in_ready;
  // Shifting in from the top leaves the first byte of a group in bits 7:0.
  assign next_word = {in_data, shreg[31:8]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      byte_cnt <= 2'd0;
      word_cnt <= '0;
      n_words  <= '0;
      csum     <= 8'd0;
      shreg    <= 32'd0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 32'd0;
      done     <= 1'b0;
      err      <= 2'b00;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_HDR;
            done     <= 1'b0;
            err      <= 2'b00;
            byte_cnt <= 2'd0;
            word_cnt <= '0;
            csum     <= 8'd0;
          end
        end
        S_HDR: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= next_word;
            if (byte_cnt == 2'd3) begin
              if (next_word > 32'(IMEM_SIZE)) begin
                state <= S_ERR;
                err   <= 2'b01;
              end else if (next_word == 32'd0) begin
                state <= S_CSUM;
              end else begin
                state   <= S_DATA;
                n_words <= CW'(next_word);
              end
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= next_word;
            csum     <= csum ^ in_data;
            if (byte_cnt == 2'd3) begin
              wr_en    <= 1'b1;
              wr_addr  <= IMEM_BITS'(word_cnt);
              wr_data  <= next_word;
              word_cnt <= word_cnt + CW'(1);
              if (word_cnt == n_words - CW'(1)) state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (in_data == csum) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 2'b10;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
